// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory arbiter.
package imem_arb_pkg;

  // Port ownership as seen from the previous cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Loader-denied cycles tolerated before the loader is forced through.
  localparam int DEFAULT_MAX_WAIT = 4;

endpackage

// File: rtl/imem_arb_rsp.sv
// Registered read-response pair: one valid/data register per requester.
// Data holds between reads; valid is a single-cycle pulse after each read grant.
module imem_arb_rsp #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fetch_rd,
  input  logic         ld_rd,
  input  logic [N-1:0] mem_q,
  output logic         fetch_valid,
  output logic [N-1:0] fetch_q,
  output logic         ld_valid,
  output logic [N-1:0] ld_q
);

  // Capture the RAM word for whichever requester was granted a read this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_q     <= '0;
      ld_valid    <= 1'b0;
      ld_q        <= '0;
    end else begin
      fetch_valid <= fetch_rd;
      ld_valid    <= ld_rd;
      if (fetch_rd) fetch_q <= mem_q;
      if (ld_rd)    ld_q    <= mem_q;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter between core fetch and program loader.
// Optional feature macro: IMEM_ARB_STARVE_EN enables the loader starvation guard.
//
// state  | meaning
// IDLE   | nobody owned the port last cycle
// FETCH  | fetch was granted last cycle
// LOCKED | loader holds the port for a burst; fetch is blocked
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int N        = 32,
  parameter int AW       = 6,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_valid,
  output logic [N-1:0]  fetch_q,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic          ld_lock,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_wdata,
  output logic          ld_gnt,
  output logic          ld_valid,
  output logic [N-1:0]  ld_q,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_q
);

  arb_state_e state_q, state_d;
  logic       starve;

`ifdef IMEM_ARB_STARVE_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_q;

  assign starve = (wait_q >= CW'(MAX_WAIT));

  // Count consecutive cycles the loader asks and is refused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                wait_q <= '0;
    else if (ld_req && !ld_gnt) wait_q <= wait_q + 1'b1;
    else                      wait_q <= '0;
  end
`else
  // Strict fetch priority: the guard can never fire in this build.
  assign starve = (MAX_WAIT < 0);
`endif

  // Ownership state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Grant decision and next ownership; no grants at all while in reset.
  always_comb begin
    state_d   = state_q;
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    if (!reset) begin
      case (state_q)
        LOCKED: begin
          ld_gnt = ld_req;
          if (!ld_lock) state_d = IDLE;
        end
        default: begin
          if (fetch_req && !(starve && ld_req)) fetch_gnt = 1'b1;
          else                                  ld_gnt    = ld_req;
          if (fetch_gnt)             state_d = FETCH;
          else if (ld_gnt && ld_lock) state_d = LOCKED;
          else                        state_d = IDLE;
        end
      endcase
    end
  end

  // RAM port follows the granted requester; fetch address parks there otherwise.
  always_comb begin
    mem_addr  = ld_gnt ? ld_addr : fetch_addr;
    mem_we    = ld_gnt & ld_we;
    mem_wdata = ld_gnt ? ld_wdata : '0;
  end

  imem_arb_rsp #(.N(N)) u_rsp (
    .clk         (clk),
    .reset       (reset),
    .fetch_rd    (fetch_gnt),
    .ld_rd       (ld_gnt & ~ld_we),
    .mem_q       (mem_q),
    .fetch_valid (fetch_valid),
    .fetch_q     (fetch_q),
    .ld_valid    (ld_valid),
    .ld_q        (ld_q)
  );

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus random traffic against a
// behavioural model of who may use the port and what each read must return.
module tb_imem_arbiter;

  localparam int N        = 32;
  localparam int AW       = 6;
  localparam int MAX_WAIT = 4;
`ifdef IMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt;
  logic          fetch_valid;
  logic [N-1:0]  fetch_q;
  logic          ld_req;
  logic          ld_we;
  logic          ld_lock;
  logic [AW-1:0] ld_addr;
  logic [N-1:0]  ld_wdata;
  logic          ld_gnt;
  logic          ld_valid;
  logic [N-1:0]  ld_q;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [N-1:0]  mem_wdata;
  logic [N-1:0]  mem_q;

  int checks = 0;
  int errors = 0;

  imem_arbiter #(.N(N), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_q(fetch_q),
    .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_valid(ld_valid), .ld_q(ld_q),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return {8'hC0, 8'(i), 16'h1234 ^ 16'(i * 7)};
  endfunction

  // Instruction RAM: synchronous write, combinational read.
  logic [N-1:0] ram [64];
  assign mem_q = ram[mem_addr];
  initial begin
    for (int i = 0; i < 64; i++) ram[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected memory contents, ownership and pending responses.
  logic [N-1:0] ref_mem [64];
  bit           m_locked;
  int           m_wait;
  bit           m_fv, m_lv;
  logic [N-1:0] m_fq, m_lq;
  bit           eg_f, eg_l;

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    m_locked = 0; m_wait = 0; m_fv = 0; m_lv = 0; m_fq = '0; m_lq = '0;
    forever begin
      @(negedge clk);
      eg_f = 0;
      eg_l = 0;
      if (reset) begin
        m_fv = 0; m_lv = 0; m_fq = '0; m_lq = '0;
      end else if (m_locked) begin
        eg_l = ld_req;
      end else if (fetch_req && !(STARVE && ld_req && m_wait >= MAX_WAIT)) begin
        eg_f = 1;
      end else begin
        eg_l = ld_req;
      end

      chk("fetch_gnt", fetch_gnt, 32'(eg_f));
      chk("ld_gnt", ld_gnt, 32'(eg_l));
      chk("mem_addr", mem_addr, 32'(eg_l ? ld_addr : fetch_addr));
      chk("mem_we", mem_we, 32'(eg_l && ld_we));
      if (eg_l && ld_we) chk("mem_wdata", mem_wdata, ld_wdata);
      chk("fetch_valid", fetch_valid, 32'(m_fv));
      chk("fetch_q", fetch_q, m_fq);
      chk("ld_valid", ld_valid, 32'(m_lv));
      chk("ld_q", ld_q, m_lq);

      if (reset) begin
        m_locked = 0;
        m_wait   = 0;
      end else begin
        m_fv = eg_f;
        if (eg_f) m_fq = ref_mem[fetch_addr];
        m_lv = eg_l && !ld_we;
        if (m_lv) m_lq = ref_mem[ld_addr];
        if (eg_l && ld_we) ref_mem[ld_addr] = ld_wdata;
        m_locked = m_locked ? ld_lock : (eg_l && ld_lock);
        m_wait   = (STARVE && ld_req && !eg_l) ? m_wait + 1 : 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int first;

  initial begin
    reset = 1'b1; fetch_req = 1'b1; fetch_addr = 6'd3;
    ld_req = 1'b1; ld_we = 1'b0; ld_lock = 1'b0; ld_addr = 6'd4; ld_wdata = '0;

    // Reset with both requesters asking.
    repeat (3) begin
      @(negedge clk);
      chk("rst_fetch_gnt", fetch_gnt, 0);
      chk("rst_ld_gnt", ld_gnt, 0);
      chk("rst_fetch_valid", fetch_valid, 0);
      chk("rst_ld_q", ld_q, 0);
    end
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("first_fetch_gnt", fetch_gnt, 1);
    chk("first_ld_gnt", ld_gnt, 0);
    chk("no_valid_after_rst", fetch_valid, 0);

    // Loader writes, fetch reads the new word back.
    tick(); fetch_req = 1'b0; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 6'd5; ld_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr5_ld_gnt", ld_gnt, 1);
    chk("wr5_mem_we", mem_we, 1);
    tick(); ld_req = 1'b0; ld_we = 1'b0; fetch_req = 1'b1; fetch_addr = 6'd5;
    @(negedge clk);
    chk("rd5_fetch_gnt", fetch_gnt, 1);
    tick(); fetch_req = 1'b0;
    @(negedge clk);
    chk("rd5_valid", fetch_valid, 1);
    chk("rd5_q", fetch_q, 32'hDEADBEEF);

    // Locked burst of four writes while fetch waits.
    tick(); ld_req = 1'b1; ld_we = 1'b1; ld_lock = 1'b1; ld_addr = 6'd0; ld_wdata = 32'h1000_0000;
    @(negedge clk);
    chk("burst0_ld_gnt", ld_gnt, 1);
    for (int i = 1; i < 4; i++) begin
      tick(); fetch_req = 1'b1; fetch_addr = 6'd6; ld_addr = AW'(i); ld_wdata = 32'h1000_0000 + 32'(i);
      @(negedge clk);
      chk("burst_fetch_gnt", fetch_gnt, 0);
      chk("burst_ld_gnt", ld_gnt, 1);
    end
    tick(); ld_lock = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
    @(negedge clk);
    chk("unlock_fetch_gnt", fetch_gnt, 0);
    tick();
    @(negedge clk);
    chk("post_unlock_fetch_gnt", fetch_gnt, 1);

    // Continuous contention: guard lets the loader in on the 5th cycle.
    tick(); ld_req = 1'b1; ld_we = 1'b0; ld_addr = 6'd7;
    first = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      @(negedge clk);
      if (ld_gnt && first == 0) first = c;
    end
    chk("starve_first_ld_gnt", 32'(first), STARVE ? 32'd5 : 32'd0);

    // Alternating reads of addresses 10 and 11.
    for (int c = 0; c < 8; c++) begin
      tick();
      fetch_req = (c % 2 == 0); fetch_addr = 6'd10;
      ld_req = (c % 2 == 1); ld_we = 1'b0; ld_addr = 6'd11;
      @(negedge clk);
      chk("alt_not_both_valid", 32'(fetch_valid & ld_valid), 0);
      if (c == 1) chk("alt_fetch_q", fetch_q, 32'hC00A1272);
      if (c == 2) chk("alt_ld_q", ld_q, 32'hC00B1279);
    end

    // Reset right after a loader read grant drops the response.
    tick(); fetch_req = 1'b0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 6'd11;
    @(negedge clk);
    chk("pre_rst_ld_gnt", ld_gnt, 1);
    tick(); reset = 1'b1; ld_req = 1'b0;
    @(negedge clk);
    chk("rst_ld_valid", ld_valid, 0);
    chk("rst_ld_q_cleared", ld_q, 0);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ld_valid", ld_valid, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset      = ($urandom_range(0, 199) == 0);
      fetch_req  = ($urandom_range(0, 3) != 0);
      fetch_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      ld_req     = ($urandom_range(0, 1) == 1);
      ld_we      = ($urandom_range(0, 1) == 1);
      ld_lock    = ($urandom_range(0, 5) == 0);
      ld_addr    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      ld_wdata   = $urandom;
    end
    tick(); reset = 1'b0; fetch_req = 1'b0; ld_req = 1'b0; ld_lock = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbitrates the single instruction-memory port between the core fetch path and a program-loader/debug port, so programs can be written into and read back from a writable 64×32 instruction memory while the single-cycle core runs. Each access is accepted in the request cycle with a combinational grant, and its response is returned registered one cycle later. The block sits between the fetch PC logic, the loader, and the instruction RAM.

## Interface
- N, 32, instruction word width
- AW, 6, address width (64 words)
- MAX_WAIT, 4, consecutive loader-denied cycles before forced loader grant (starvation guard only)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- fetch_req  in  1  fetch read request, held until granted
- fetch_addr  in  AW  fetch word address
- fetch_gnt  out  1  fetch access accepted this cycle
- fetch_valid  out  1  fetch read data valid (cycle after grant)
- fetch_q  out  N  fetch read data
- ld_req  in  1  loader request, held until granted
- ld_we  in  1  1 = write, 0 = read
- ld_lock  in  1  keep port for loader while asserted (burst)
- ld_addr  in  AW  loader word address
- ld_wdata  in  N  loader write data
- ld_gnt  out  1  loader access accepted this cycle
- ld_valid  out  1  loader read data valid (reads only)
- ld_q  out  N  loader read data
- mem_addr  out  AW  to RAM address
- mem_we  out  1  to RAM write enable
- mem_wdata  out  N  to RAM write data
- mem_q  in  N  from RAM, combinational read of mem_addr

## Operation
- States: IDLE (no owner), FETCH (fetch owned last cycle), LOCKED (loader holds lock).
- IDLE/FETCH: fetch_req wins, unless the starvation guard forces the loader; otherwise ld_req wins.
- Loader grant with ld_lock=1 → LOCKED. In LOCKED, only the loader is granted; fetch_gnt=0. Return to IDLE on the first cycle with ld_lock=0, which is still a valid loader grant if ld_req=1.
- At most one grant per cycle. mem_addr, mem_we and mem_wdata follow the granted requester. With no grant: mem_we=0 and mem_addr=fetch_addr.
- mem_we = ld_gnt & ld_we. A write produces no response.
- Read response: on a granted read, capture mem_q in the *_q register; *_valid=1 for exactly the next cycle. *_q holds its value until the next read.
- Same-address write followed by read: the read returns the new data. The RAM is write-through on the next cycle.

## Timing
- Grant is combinational from req/state in the same cycle. Read latency is 1 cycle from grant to valid.
- Back-to-back grants every cycle are allowed. Full throughput is 1 access/cycle.
- Reset values: state=IDLE, wait counter=0, fetch_valid=0, ld_valid=0, fetch_q=0, ld_q=0. Grants are 0 while reset is asserted.
- Reset mid-operation discards the pending response. Valid must not assert in the cycle after reset deasserts.
- Simultaneous fetch_req and ld_req in IDLE/FETCH: fetch is granted unless the guard fires.

## Configuration
- IMEM_ARB_STARVE_EN defined:
  - A counter increments each cycle ld_req=1 and ld_gnt=0, and clears on ld_gnt or ld_req=0.
  - When the count reaches MAX_WAIT, the loader is granted over fetch for one access.
  - Counter width is $clog2(MAX_WAIT+1).
- Undefined: strict fetch priority outside LOCKED. The loader is served only in cycles without fetch_req. No counter exists.

## Structure
- Package imem_arb_pkg: state enum (IDLE, FETCH, LOCKED) and a default MAX_WAIT constant.
- One sub-module, imem_arb_rsp: the response register pair (valid + data per requester), with async reset.
- Grant logic is combinational in the top.

## Test plan
- Reset with both requests high → no grants, valid=0, q=0 until reset drops. After release, fetch is granted first.
- Loader write addr 5 = 0xDEADBEEF, then fetch read addr 5 → fetch_valid next cycle, fetch_q=0xDEADBEEF.
- Loader lock burst of 4 writes (addr 0–3) with fetch_req held → fetch_gnt=0 for 4 cycles, granted on the cycle after ld_lock drops.
- Continuous fetch_req plus ld_req with IMEM_ARB_STARVE_EN and MAX_WAIT=4 → ld_gnt on the 5th cycle. Without the macro, ld_gnt never asserts.
- Alternating fetch/loader reads at addr 10/11 every cycle → valid and data correct each cycle, never both valid together.
- Reset asserted the cycle after a read grant → no valid pulse, ld_q=0.
